// File: rtl/md_unit_param.sv
// Parametrised multiply/divide unit with HI/LO registers for the EX stage.
// Operands are latched at launch; the result is computed at the commit edge.
module md_unit_param #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hilo_sel,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OpMult  = 4'd0;
  localparam logic [3:0] OpMultu = 4'd1;
  localparam logic [3:0] OpDiv   = 4'd2;
  localparam logic [3:0] OpDivu  = 4'd3;
  localparam logic [3:0] OpMthi  = 4'd4;
  localparam logic [3:0] OpMtlo  = 4'd5;
  localparam logic [3:0] OpMsub  = 4'd6;
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsubu = 4'd9;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0]  MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0]  DivLoad  = CntW'(DIV_CYCLES - 1);
  localparam logic [WIDTH-1:0] MinVal   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;

  function automatic logic is_long(input logic [3:0] o);
    return o inside {OpMult, OpMultu, OpDiv, OpDivu, OpMsub, OpMadd, OpMaddu, OpMsubu};
  endfunction

  assign busy      = (state_q == StRun);
  assign stall_req = busy | (start & is_long(op) & ~cancel);
  assign rdata     = hilo_sel ? lo : hi;

  logic [2*WIDTH-1:0]      a_sx, b_sx, a_zx, b_zx, prod_s, prod_u, hilo, result;
  logic signed [WIDTH-1:0] a_sg, b_sg, quo_s, rem_s;
  logic                    div_ok;

  always_comb begin
    a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    a_zx   = {{WIDTH{1'b0}}, a_q};
    b_zx   = {{WIDTH{1'b0}}, b_q};
    prod_s = a_sx * b_sx;
    prod_u = a_zx * b_zx;
    hilo   = {hi, lo};
    a_sg   = a_q;
    b_sg   = b_q;
    div_ok = (b_q != '0);
    quo_s  = '0;
    rem_s  = '0;
    if (div_ok) begin
      // Most-negative / -1 overflows the quotient; define it as wrap with zero remainder.
      if (a_q == MinVal && b_q == '1) begin
        quo_s = a_sg;
      end else begin
        quo_s = a_sg / b_sg;
        rem_s = a_sg % b_sg;
      end
    end
    case (op_q)
      OpMult:  result = prod_s;
      OpMultu: result = prod_u;
      OpMadd:  result = hilo + prod_s;
      OpMaddu: result = hilo + prod_u;
      OpMsub:  result = hilo - prod_s;
      OpMsubu: result = hilo - prod_u;
      OpDiv:   result = div_ok ? {rem_s, quo_s} : hilo;
      OpDivu:  result = div_ok ? {a_q % b_q, a_q / b_q} : hilo;
      default: result = hilo;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !cancel) begin
            if (op == OpMthi) begin
              hi <= a;
            end else if (op == OpMtlo) begin
              lo <= a;
            end else if (is_long(op)) begin
              op_q    <= op;
              a_q     <= a;
              b_q     <= b;
              cnt_q   <= (op == OpDiv || op == OpDivu) ? DivLoad : MultLoad;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          // Cancel takes priority over a coincident commit.
          if (cancel) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            {hi, lo} <= result;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_param.sv
// Scoreboard bench for md_unit_param: default instance plus a 16-bit,
// MULT_CYCLES=1, DIV_CYCLES=33 instance.
module tb_md_unit_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start0, cancel0, sel0, busy0, stall0;
  logic [3:0]  op0;
  logic [31:0] a0, b0, rdata0, hi0, lo0;

  logic        start1, cancel1, sel1, busy1, stall1;
  logic [3:0]  op1;
  logic [15:0] a1, b1, rdata1, hi1, lo1;

  md_unit_param u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .op(op0), .a(a0), .b(b0),
    .cancel(cancel0), .hilo_sel(sel0), .rdata(rdata0), .busy(busy0),
    .stall_req(stall0), .hi(hi0), .lo(lo0)
  );

  md_unit_param #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(33)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op1), .a(a1), .b(b1),
    .cancel(cancel1), .hilo_sel(sel1), .rdata(rdata1), .busy(busy1),
    .stall_req(stall1), .hi(hi1), .lo(lo1)
  );

  int          checks = 0;
  int          errors = 0;
  int          cnt;
  logic [63:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  logic [63:0] m_hl;
  logic [63:0] e0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model0(input logic [3:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [63:0] hl);
    logic [63:0] ps, pu;
    int sx, sy;
    ps = longint'($signed(x)) * longint'($signed(y));
    pu = {32'h0, x} * {32'h0, y};
    sx = x;
    sy = y;
    case (o)
      4'd0: return ps;
      4'd1: return pu;
      4'd7: return hl + ps;
      4'd8: return hl + pu;
      4'd6: return hl - ps;
      4'd9: return hl - pu;
      4'd2: begin
        if (y == 0) return hl;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      4'd3: return (y == 0) ? hl : {x % y, x / y};
      4'd4: return {x, hl[31:0]};
      4'd5: return {hl[63:32], x};
      default: return hl;
    endcase
  endfunction

  task automatic do_op0(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int n);
    logic [63:0] e;
    int c;
    @(negedge clk);
    start0 = 1'b1; op0 = o; a0 = x; b0 = y;
    #1 check("stall_req0", stall0, (n > 0));
    exp0_q.push_back(model0(o, x, y, m_hl));
    @(negedge clk);
    start0 = 1'b0;
    c = 0;
    while (busy0 && c < 100) begin
      c++;
      @(negedge clk);
    end
    check("busy_len0", c, n);
    e = exp0_q.pop_front();
    check("hilo0", {hi0, lo0}, e);
    m_hl = e;
  endtask

  task automatic do_op1(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                        input int n, input logic [31:0] exp);
    logic [31:0] e;
    int c;
    @(negedge clk);
    start1 = 1'b1; op1 = o; a1 = x; b1 = y;
    exp1_q.push_back(exp);
    @(negedge clk);
    start1 = 1'b0;
    c = 0;
    while (busy1 && c < 100) begin
      c++;
      @(negedge clk);
    end
    check("busy_len1", c, n);
    e = exp1_q.pop_front();
    check("hilo1", {hi1, lo1}, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    start0 = 0; cancel0 = 0; sel0 = 0; op0 = 0; a0 = 0; b0 = 0;
    start1 = 0; cancel1 = 0; sel1 = 0; op1 = 0; a1 = 0; b1 = 0;
    m_hl = '0;
    repeat (2) @(negedge clk);
    check("rst_hilo0", {hi0, lo0}, 64'h0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_hilo1", {hi1, lo1}, 32'h0);
    check("rst_busy1", busy1, 1'b0);
    reset = 1'b1;

    // Asynchronous reset during RUN
    @(negedge clk); start0 = 1; op0 = 4'd0; a0 = 7; b0 = 6;
    @(negedge clk); start0 = 0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("rstrun_busy", busy0, 1'b0);
    check("rstrun_hilo", {hi0, lo0}, 64'h0);
    @(negedge clk); reset = 1'b1;
    repeat (8) @(negedge clk);
    check("rstrun_nocommit", {hi0, lo0}, 64'h0);
    check("rstrun_busy_late", busy0, 1'b0);

    do_op0(4'd0, 32'hFFFF_FFFF, 32'd2, 5);
    check("mult_const", {hi0, lo0}, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op0(4'd1, 32'hFFFF_FFFF, 32'd2, 5);
    check("multu_const", {hi0, lo0}, 64'h0000_0001_FFFF_FFFE);
    do_op0(4'd2, 32'hFFFF_FFF9, 32'd2, 10);
    check("div_const", {hi0, lo0}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op0(4'd4, 32'd5, 32'd0, 0);
    do_op0(4'd5, 32'd9, 32'd0, 0);
    do_op0(4'd3, 32'd7, 32'd0, 10);
    check("divu0_const", {hi0, lo0}, 64'h0000_0005_0000_0009);
    do_op0(4'd4, 32'h1, 32'd0, 0);
    do_op0(4'd5, 32'hFFFF_FFFF, 32'd0, 0);
    do_op0(4'd7, 32'd1, 32'd1, 5);
    check("madd_const", {hi0, lo0}, 64'h0000_0002_0000_0000);
    do_op0(4'd6, 32'd1, 32'd1, 5);
    check("msub_const", {hi0, lo0}, 64'h0000_0001_FFFF_FFFF);
    do_op0(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    do_op0(4'd9, 32'd3, 32'd4, 5);
    do_op0(4'd0, 32'h8000_0000, 32'h8000_0000, 5);
    do_op0(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check("div_ovf_const", {hi0, lo0}, 64'h0000_0000_8000_0000);
    do_op0(4'd2, 32'd7, 32'hFFFF_FFFE, 10);
    do_op0(4'd3, 32'd100, 32'd7, 10);
    do_op0(4'd12, 32'd1, 32'd2, 0);

    sel0 = 1'b0; #1 check("rdata_hi", rdata0, m_hl[63:32]);
    sel0 = 1'b1; #1 check("rdata_lo", rdata0, m_hl[31:0]);

    // Cancel in RUN cycle 3
    @(negedge clk); start0 = 1; op0 = 4'd0; a0 = 3; b0 = 3;
    @(negedge clk); start0 = 0;
    @(negedge clk);
    @(negedge clk); cancel0 = 1;
    @(negedge clk); cancel0 = 0;
    check("cancel3_busy", busy0, 1'b0);
    check("cancel3_hilo", {hi0, lo0}, m_hl);
    repeat (6) @(negedge clk);
    check("cancel3_late", {hi0, lo0}, m_hl);

    // Cancel on the commit edge
    @(negedge clk); start0 = 1; op0 = 4'd0; a0 = 3; b0 = 3;
    @(negedge clk); start0 = 0;
    repeat (4) @(negedge clk);
    check("precommit_busy", busy0, 1'b1);
    cancel0 = 1;
    @(negedge clk); cancel0 = 0;
    check("cancelc_busy", busy0, 1'b0);
    check("cancelc_hilo", {hi0, lo0}, m_hl);

    // Cancel blocks starts in IDLE
    @(negedge clk); start0 = 1; op0 = 4'd4; a0 = 32'hDEAD_BEEF; cancel0 = 1;
    @(negedge clk); op0 = 4'd0;
    #1 check("stall_cancel", stall0, 1'b0);
    @(negedge clk); start0 = 0; cancel0 = 0;
    check("cancel_mthi", hi0, m_hl[63:32]);
    check("cancel_mult_busy", busy0, 1'b0);

    // Start while busy is ignored
    @(negedge clk); start0 = 1; op0 = 4'd0; a0 = 2; b0 = 3;
    exp0_q.push_back(model0(4'd0, 32'd2, 32'd3, m_hl));
    @(negedge clk); op0 = 4'd1; a0 = 5; b0 = 5;
    #1 check("stall_busy", stall0, 1'b1);
    @(negedge clk); start0 = 0;
    cnt = 1;
    while (busy0 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_len_ign", cnt, 5);
    e0 = exp0_q.pop_front();
    check("hilo_ign", {hi0, lo0}, e0);
    m_hl = e0;
    @(negedge clk);
    check("no_second_launch", busy0, 1'b0);

    // 16-bit, MULT_CYCLES=1, DIV_CYCLES=33
    do_op1(4'd0, 16'hFFFF, 16'd2, 1, 32'hFFFF_FFFE);
    do_op1(4'd1, 16'hFFFF, 16'hFFFF, 1, 32'hFFFE_0001);
    do_op1(4'd4, 16'hFFFF, 16'd0, 0, 32'hFFFF_0001);
    do_op1(4'd5, 16'hFFFF, 16'd0, 0, 32'hFFFF_FFFF);
    do_op1(4'd8, 16'd1, 16'd1, 1, 32'h0000_0000);
    do_op1(4'd6, 16'd1, 16'd1, 1, 32'hFFFF_FFFF);
    do_op1(4'd2, 16'd100, 16'd7, 33, 32'h0002_000E);
    do_op1(4'd2, 16'h8000, 16'hFFFF, 33, 32'h0000_8000);
    sel1 = 1'b1; #1 check("rdata1_lo", rdata1, 16'h8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
